// File: rtl/if_stage_if.sv
// Instruction-memory request/response bus between the fetch stage and imem.
interface if_stage_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;

  modport master (
    output imem_req_valid,
    output imem_addr,
    input  imem_req_ready,
    input  imem_rsp_valid,
    input  imem_rsp_data
  );

  modport slave (
    input  imem_req_valid,
    input  imem_addr,
    output imem_req_ready,
    output imem_rsp_valid,
    output imem_rsp_data
  );
endinterface

// File: rtl/if_stage.sv
// Instruction fetch stage: single-outstanding imem request, one-entry hold
// buffer for responses that arrive while decode is stalled, and IF/ID register.
module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  if_stage_if.master  imem,
  output logic        id_valid,
  output logic [31:0] id_pc,
  output logic [31:0] id_instr,
  output logic [6:0]  id_op,
  output logic [2:0]  id_funct3,
  output logic [6:0]  id_funct7,
  output logic [31:0] fetch_cnt
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2,
    S_DROP = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] w_pc_nxt;
  logic [31:0] r_hold;
  logic        r_id_valid;
  logic [31:0] r_id_pc;
  logic [31:0] r_id_instr;
  logic [31:0] r_fetch_cnt;

  logic        w_load;
  logic [31:0] w_load_data;
  logic        w_capture;
  logic [31:0] w_redir_pc;
  logic [31:0] w_pc_inc;
  logic        w_accept;

  assign w_redir_pc = redirect_pc & ~32'd3;
  assign w_pc_inc   = r_pc + 32'd4;
  assign w_accept   = (r_state == S_REQ) && imem.imem_req_ready;

  assign imem.imem_req_valid = (r_state == S_REQ);
  assign imem.imem_addr      = r_pc;

  assign id_valid  = r_id_valid;
  assign id_pc     = r_id_pc;
  assign id_instr  = r_id_instr;
  assign id_op     = r_id_instr[6:0];
  assign id_funct3 = r_id_instr[14:12];
  assign id_funct7 = r_id_instr[31:25];
  assign fetch_cnt = r_fetch_cnt;

  // Fetch FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_REQ;
    else     r_state <= w_state_nxt;
  end

  // Next state, next pc, and whether IF/ID loads or the hold buffer captures
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_load      = 1'b0;
    w_load_data = imem.imem_rsp_data;
    w_capture   = 1'b0;
    unique case (r_state)
      S_REQ: begin
        if (redirect_valid) begin
          w_pc_nxt    = w_redir_pc;
          w_state_nxt = w_accept ? S_DROP : S_REQ;
        end else if (w_accept) begin
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (redirect_valid) begin
          w_pc_nxt    = w_redir_pc;
          w_state_nxt = imem.imem_rsp_valid ? S_REQ : S_DROP;
        end else if (imem.imem_rsp_valid) begin
          if (!r_id_valid || !stall) begin
            w_load      = 1'b1;
            w_pc_nxt    = w_pc_inc;
            w_state_nxt = S_REQ;
          end else begin
            w_capture   = 1'b1;
            w_state_nxt = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (redirect_valid) begin
          w_pc_nxt    = w_redir_pc;
          w_state_nxt = S_REQ;
        end else if (!stall) begin
          w_load      = 1'b1;
          w_load_data = r_hold;
          w_pc_nxt    = w_pc_inc;
          w_state_nxt = S_REQ;
        end
      end
      S_DROP: begin
        // A redirect here still has the stale response in flight unless it
        // arrives this same cycle, so only leave DROP once it has been seen.
        if (redirect_valid) w_pc_nxt = w_redir_pc;
        if (imem.imem_rsp_valid) w_state_nxt = S_REQ;
      end
      default: w_state_nxt = S_REQ;
    endcase
  end

  // Program counter and hold buffer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc   <= RESET_PC;
      r_hold <= '0;
    end else begin
      r_pc <= w_pc_nxt;
      if (w_capture) r_hold <= imem.imem_rsp_data;
    end
  end

  // IF/ID register: redirect flushes, stall holds a live slot, else load or bubble
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_id_valid  <= 1'b0;
      r_id_pc     <= '0;
      r_id_instr  <= NOP_INSTR;
      r_fetch_cnt <= '0;
    end else if (redirect_valid) begin
      r_id_valid <= 1'b0;
      r_id_instr <= NOP_INSTR;
    end else if (stall && r_id_valid) begin
      r_id_valid <= r_id_valid;
    end else if (w_load) begin
      r_id_valid  <= 1'b1;
      r_id_pc     <= r_pc;
      r_id_instr  <= w_load_data;
      r_fetch_cnt <= r_fetch_cnt + 32'd1;
    end else begin
      r_id_valid <= 1'b0;
      r_id_instr <= NOP_INSTR;
    end
  end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, first fetch address after reset.
REQ-002 Parameter: NOP_INSTR, 32'h0000_0013 (addi x0,x0,0), instruction presented to decode while the slot is empty.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 stall  in  1  decode cannot accept; hold IF/ID register.
REQ-006 redirect_valid  in  1  taken branch/jump; flush and refetch.
REQ-007 redirect_pc  in  32  new fetch address.
REQ-008 imem_req_valid  out  1  fetch request.
REQ-009 imem_req_ready  in  1  memory accepts request.
REQ-010 imem_addr  out  32  fetch address, equals pc.
REQ-011 imem_rsp_valid  in  1  instruction data valid; not back-pressurable.
REQ-012 imem_rsp_data  in  32  returned instruction.
REQ-013 id_valid  out  1  IF/ID slot holds a live instruction.
REQ-014 id_pc  out  32  PC of id_instr.
REQ-015 id_instr  out  32  instruction to decode.
REQ-016 id_op / id_funct3 / id_funct7  out  7/3/7  id_instr[6:0] / [14:12] / [31:25], combinational from the IF/ID register.
REQ-017 fetch_cnt  out  32  count of instructions loaded into IF/ID.

Function
REQ-018 States: REQ, WAIT, HOLD, DROP; at most one outstanding request.
REQ-019 imem_req_valid SHALL be 1 only in REQ; request accepted on req_valid & req_ready, then REQ->WAIT.
REQ-020 WAIT, rsp_valid, no redirect, slot free (~id_valid | ~stall): load id_valid=1, id_pc=pc, id_instr=rsp_data; pc<=pc+4; ->REQ.
REQ-021 WAIT, rsp_valid, no redirect, slot busy (id_valid & stall): capture rsp_data in 32-bit hold buffer; pc unchanged; ->HOLD.
REQ-022 HOLD, ~stall, no redirect: load IF/ID from hold buffer; pc<=pc+4; ->REQ.
REQ-023 Redirect in REQ without handshake: pc<=redirect_pc; stay REQ. Redirect coincident with accepted request: pc<=redirect_pc; ->DROP.
REQ-024 Redirect in WAIT: pc<=redirect_pc; ->REQ if rsp_valid same cycle (response discarded), else ->DROP.
REQ-025 Redirect in HOLD: hold buffer discarded; pc<=redirect_pc; ->REQ.
REQ-026 DROP: rsp_valid discarded, ->REQ; further redirect updates pc, stays DROP.
REQ-027 redirect_pc[1:0] SHALL be forced to 2'b00 when loaded into pc.
REQ-028 IF/ID priority: rst > redirect_valid > stall > load; redirect clears id_valid and sets id_instr=NOP_INSTR next edge.
REQ-029 stall with id_valid=1: id_valid/id_pc/id_instr unchanged.
REQ-030 Neither stalled nor loaded: id_valid<=0, id_instr<=NOP_INSTR, id_pc unchanged.
REQ-031 id_valid=0 SHALL always coincide with id_instr=NOP_INSTR.
REQ-032 pc+4 and fetch_cnt+1 wrap modulo 2^32; fetch_cnt increments once per IF/ID load, never on discarded responses.
REQ-033 Fetch-to-decode latency: request accept at edge N, response in cycle N+k, id_valid=1 from edge N+k+1.

Reset
REQ-034 On rst: pc=RESET_PC, state=REQ, id_valid=0, id_pc=0, id_instr=NOP_INSTR, hold buffer=0, fetch_cnt=0; imem_req_valid=1 in the first cycle after release.
REQ-035 rst asserted mid-transaction SHALL abandon the outstanding request; any later response with no request outstanding SHALL be ignored.

Verification
REQ-036 Reset release, ready=1, 1-cycle response 0x00500093 -> imem_addr 0x0, then id_valid=1, id_pc=0x0, id_op=0x13, id_funct3=0, fetch_cnt=1; next imem_addr 0x4.
REQ-037 id_valid=1, stall=1, response 0x40208133 arrives -> state HOLD, IF/ID unchanged; stall drops -> id_instr=0x40208133, id_funct7=0x20, pc advances by 4.
REQ-038 Redirect to 0x103 during WAIT, response next cycle -> response discarded, fetch_cnt unchanged, next imem_addr 0x100, id_valid=0, id_instr=0x13.
REQ-039 Redirect coincident with stall and id_valid=1 -> id_valid=0 next edge (redirect wins).
REQ-040 pc=0xFFFF_FFFC fetch completes -> next imem_addr 0x0; fetch_cnt preloaded to 0xFFFF_FFFF wraps to 0.
REQ-041 rst pulsed while in WAIT -> outputs at reset values immediately (asynchronous); stray rsp_valid next cycle not loaded.
